stream_seq_checker: RTL and testbench

- Stream sink that consumes a 32-bit incrementing-count data stream, such as a DMA transfer of free-running counter output, and verifies it.
- Checks that each accepted beat equals the previous beat plus one, and that tlast lands on the configured packet boundary.
- Maintains beat, packet and error statistics plus first-error capture for software readout.
- Sits at the S2MM/receive end of the DMA loopback test path.

---
 rtl/stream_seq_checker_if.sv | 30 +++
 rtl/stream_seq_checker.sv | 121 ++++++++++++
 tb/tb_stream_seq_checker.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_seq_checker_if.sv
// Stream handshake bundle for the sequence checker.
//   tdata  : stream data, DATA_W bits
//   tvalid : source has a beat
//   tlast  : beat closes a packet
//   tready : sink can take the beat
// master drives data/valid/last, slave drives ready.
interface stream_seq_checker_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/stream_seq_checker.sv
// Stream sink that verifies an incrementing-count data stream and the packet boundaries.
// Each accepted beat must equal the previous beat plus one. When PKT_LEN is non-zero,
// tlast must land on every PKT_LEN-th beat. Errors are counted, flagged sticky and the
// first data mismatch is captured for software readout.
//
// Ports:
//   clk, rstn      : clock, synchronous active-low reset
//   enable         : checker enable, gates s.tready
//   clear          : one-cycle synchronous clear of state and statistics
//   s              : stream slave (tdata/tvalid/tlast in, tready out)
//   beat_count     : accepted beats (wraps)
//   pkt_count      : accepted tlast beats (wraps)
//   err_count      : data mismatches (saturating)
//   len_err_count  : tlast position errors (saturating)
//   err_flag       : sticky, any data or length error since clear/reset
//   first_err_data : s.tdata of the first data mismatch
//   first_err_exp  : expected value at the first data mismatch
module stream_seq_checker #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned PKT_LEN       = 256,
  parameter int unsigned SYNC_ON_FIRST = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              clear,
  stream_seq_checker_if.slave s,
  output logic [31:0]       beat_count,
  output logic [31:0]       pkt_count,
  output logic [15:0]       err_count,
  output logic [15:0]       len_err_count,
  output logic              err_flag,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] first_err_exp
);

  typedef enum logic [0:0] {StSync, StCheck} state_e;

  localparam state_e      InitState = (SYNC_ON_FIRST != 0) ? StSync : StCheck;
  localparam logic [31:0] LastIdx   = (PKT_LEN == 0) ? 32'd0 : 32'(PKT_LEN - 1);

  state_e            state_q;
  logic [DATA_W-1:0] expected_q;
  logic [31:0]       idx_q;
  logic              captured_q;

  logic accept;
  logic data_err;
  logic at_boundary;
  logic len_err;

  assign s.tready = enable & rstn & ~clear;
  assign accept   = s.tvalid & s.tready;

  always_comb begin
    data_err    = (state_q == StCheck) && (s.tdata != expected_q);
    at_boundary = (PKT_LEN != 0) && (idx_q == LastIdx);
    // Covers both early tlast and missing tlast on the boundary beat.
    len_err     = (PKT_LEN != 0) && (s.tlast != at_boundary);
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      state_q        <= InitState;
      expected_q     <= '0;
      idx_q          <= '0;
      captured_q     <= 1'b0;
      beat_count     <= '0;
      pkt_count      <= '0;
      err_count      <= '0;
      len_err_count  <= '0;
      err_flag       <= 1'b0;
      first_err_data <= '0;
      first_err_exp  <= '0;
    end else if (accept) begin
      beat_count <= beat_count + 32'd1;
      if (s.tlast) begin
        pkt_count <= pkt_count + 32'd1;
      end

      unique case (state_q)
        StSync: begin
          expected_q <= s.tdata + DATA_W'(1);
          state_q    <= StCheck;
        end
        StCheck: begin
          if (data_err) begin
            if (err_count != 16'hFFFF) begin
              err_count <= err_count + 16'd1;
            end
            if (!captured_q) begin
              first_err_data <= s.tdata;
              first_err_exp  <= expected_q;
              captured_q     <= 1'b1;
            end
            // Resync on the received value so a single glitch costs one error.
            expected_q <= s.tdata + DATA_W'(1);
          end else begin
            expected_q <= expected_q + DATA_W'(1);
          end
        end
        default: state_q <= InitState;
      endcase

      if (len_err && (len_err_count != 16'hFFFF)) begin
        len_err_count <= len_err_count + 16'd1;
      end
      if (data_err || len_err) begin
        err_flag <= 1'b1;
      end

      // A missing tlast still realigns the index to the expected boundary.
      if (s.tlast || at_boundary) begin
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_stream_seq_checker.sv
// Self-checking bench for stream_seq_checker (DATA_W=32, PKT_LEN=256, SYNC_ON_FIRST=1).
module tb_stream_seq_checker;

  localparam int unsigned DW = 32;
  localparam int unsigned PL = 256;

  logic clk    = 1'b0;
  logic rstn   = 1'b0;
  logic enable = 1'b0;
  logic clear  = 1'b0;

  stream_seq_checker_if #(.DATA_W(DW)) sif ();

  logic [31:0]   beat_count;
  logic [31:0]   pkt_count;
  logic [15:0]   err_count;
  logic [15:0]   len_err_count;
  logic          err_flag;
  logic [DW-1:0] first_err_data;
  logic [DW-1:0] first_err_exp;

  stream_seq_checker #(
    .DATA_W       (DW),
    .PKT_LEN      (PL),
    .SYNC_ON_FIRST(1)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .clear         (clear),
    .s             (sif.slave),
    .beat_count    (beat_count),
    .pkt_count     (pkt_count),
    .err_count     (err_count),
    .len_err_count (len_err_count),
    .err_flag      (err_flag),
    .first_err_data(first_err_data),
    .first_err_exp (first_err_exp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: tracks the stream as "have we seen a value yet, what comes next,
  // where are we inside the packet", and derives every statistic from those rules.
  bit          m_seeded = 1'b0;
  logic [31:0] m_next   = '0;
  int unsigned m_pos    = 0;
  logic [31:0] m_beats  = '0;
  logic [31:0] m_pkts   = '0;
  int unsigned m_err    = 0;
  int unsigned m_len    = 0;
  bit          m_flag   = 1'b0;
  bit          m_cap    = 1'b0;
  logic [31:0] m_fd     = '0;
  logic [31:0] m_fe     = '0;
  logic [31:0] m_d;
  bit          m_last;
  bit          m_bound;

  always @(posedge clk) begin
    if (!rstn || clear) begin
      m_seeded = 1'b0;
      m_next   = '0;
      m_pos    = 0;
      m_beats  = '0;
      m_pkts   = '0;
      m_err    = 0;
      m_len    = 0;
      m_flag   = 1'b0;
      m_cap    = 1'b0;
      m_fd     = '0;
      m_fe     = '0;
    end else if (enable && sif.tvalid) begin
      m_d    = sif.tdata;
      m_last = sif.tlast;
      m_beats = m_beats + 1;
      if (m_last) m_pkts = m_pkts + 1;
      if (m_seeded && (m_d != m_next)) begin
        if (m_err < 65535) m_err++;
        m_flag = 1'b1;
        if (!m_cap) begin
          m_fd  = m_d;
          m_fe  = m_next;
          m_cap = 1'b1;
        end
      end
      m_seeded = 1'b1;
      m_next   = m_d + 32'd1;
      m_bound  = (m_pos == PL - 1);
      if (m_last != m_bound) begin
        if (m_len < 65535) m_len++;
        m_flag = 1'b1;
      end
      m_pos = (m_last || m_bound) ? 0 : m_pos + 1;
    end
  end

  always @(negedge clk) begin
    chk("tready", sif.tready, rstn & enable & ~clear);
    chk("beat_count", beat_count, m_beats);
    chk("pkt_count", pkt_count, m_pkts);
    chk("err_count", err_count, m_err);
    chk("len_err_count", len_err_count, m_len);
    chk("err_flag", err_flag, m_flag);
    chk("first_err_data", first_err_data, m_fd);
    chk("first_err_exp", first_err_exp, m_fe);
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic beat(input logic [31:0] d, input logic last);
    sif.tdata  = d;
    sif.tlast  = last;
    sif.tvalid = 1'b1;
    @(posedge clk);
    #1;
    sif.tvalid = 1'b0;
    sif.tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    sif.tvalid = 1'b0;
    sif.tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    sif.tvalid = 1'b0;
    clear      = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] b, input logic [31:0] p,
                           input logic [15:0] e, input logic [15:0] l, input logic f);
    chk({tag, ".beats"}, beat_count, b);
    chk({tag, ".pkts"}, pkt_count, p);
    chk({tag, ".errs"}, err_count, e);
    chk({tag, ".len_errs"}, len_err_count, l);
    chk({tag, ".flag"}, err_flag, f);
  endtask

  logic [31:0] nd;
  logic [31:0] hs;
  int unsigned pos;

  initial begin
    sif.tdata  = '0;
    sif.tvalid = 1'b0;
    sif.tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_stats("reset", 0, 0, 0, 0, 1'b0);
    chk("reset.fed", first_err_data, 0);
    chk("reset.fee", first_err_exp, 0);
    chk("reset.tready", sif.tready, 1'b0);

    // Two clean 256-beat packets.
    rstn   = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 512; i++) beat(32'h10 + i, (i % 256) == 255);
    idle(2);
    chk_stats("clean", 512, 2, 0, 0, 1'b0);

    // Wrap through zero after a seed.
    do_clear();
    chk_stats("clear1", 0, 0, 0, 0, 1'b0);
    beat(32'hFFFF_FFFE, 1'b0);
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'h0000_0000, 1'b0);
    beat(32'h0000_0001, 1'b0);
    idle(1);
    chk_stats("wrap", 4, 0, 0, 0, 1'b0);

    // Two gaps, resync in between.
    do_clear();
    beat(5, 1'b0);
    beat(6, 1'b0);
    beat(7, 1'b0);
    beat(9, 1'b0);
    beat(10, 1'b0);
    beat(12, 1'b0);
    idle(1);
    chk_stats("gaps", 6, 0, 2, 0, 1'b1);
    chk("gaps.fed", first_err_data, 9);
    chk("gaps.fee", first_err_exp, 8);

    // Early tlast, then a packet missing its tlast, then a correct packet.
    do_clear();
    nd = 32'h1000;
    for (int i = 0; i <= 100; i++) begin beat(nd, i == 100); nd++; end
    for (int i = 0; i < 256; i++) begin beat(nd, 1'b0); nd++; end
    idle(1);
    chk_stats("len", 357, 1, 0, 2, 1'b1);
    for (int i = 0; i < 256; i++) begin beat(nd, i == 255); nd++; end
    idle(1);
    chk_stats("realign", 613, 2, 0, 2, 1'b1);

    // Random valid gaps and enable toggling on a clean stream.
    do_clear();
    nd  = 32'hA000_0000;
    hs  = '0;
    pos = 0;
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      sif.tvalid = ($urandom_range(0, 3) != 0);
      sif.tdata  = nd;
      sif.tlast  = (pos == PL - 1);
      @(posedge clk);
      #1;
      if (enable && sif.tvalid) begin
        hs++;
        nd++;
        pos = (pos == PL - 1) ? 0 : pos + 1;
      end
    end
    enable = 1'b1;
    idle(2);
    chk("rand.beats", beat_count, hs);
    chk("rand.errs", err_count, 0);
    chk("rand.len_errs", len_err_count, 0);
    chk("rand.flag", err_flag, 1'b0);

    // Random corruption and stray tlast across a data wrap; model-checked only.
    do_clear();
    nd  = 32'hFFFF_FF80;
    pos = 0;
    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      sif.tvalid = ($urandom_range(0, 3) != 0);
      sif.tdata  = ($urandom_range(0, 29) == 0) ? (nd ^ (32'd1 << $urandom_range(0, 31))) : nd;
      sif.tlast  = (pos == PL - 1) ^ ($urandom_range(0, 59) == 0);
      @(posedge clk);
      #1;
      if (enable && sif.tvalid) begin
        nd  = sif.tdata + 32'd1;
        pos = (pos == PL - 1) ? 0 : pos + 1;
      end
    end
    enable = 1'b1;
    idle(2);

    // Clear on the same cycle as a valid beat: beat dropped, next beat seeds.
    sif.tdata  = 32'h40;
    sif.tvalid = 1'b1;
    clear      = 1'b1;
    #1;
    chk("clrbeat.tready", sif.tready, 1'b0);
    @(posedge clk);
    #1;
    clear      = 1'b0;
    sif.tvalid = 1'b0;
    chk_stats("clrbeat", 0, 0, 0, 0, 1'b0);
    beat(32'h41, 1'b0);
    beat(32'h42, 1'b0);
    idle(1);
    chk_stats("seed", 2, 0, 0, 0, 1'b0);
    chk("seed.fed", first_err_data, 0);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
